// File: rtl/sb_cfg_pkg.sv
// Shared types and helpers for the east/south switch block with a
// double-buffered prog_clk configuration chain.
package sb_cfg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sb_cfg_state_e;

  // Select width of one track mux; a 2:1 mux still needs one select bit.
  function automatic int sel_w(input int mux_size);
    return (mux_size <= 2) ? 1 : $clog2(mux_size);
  endfunction

  // Channel track feeding input k (k >= 1) of output track t. The twist
  // rotates the channel so neighbouring outputs tap different tracks.
  function automatic int twist_idx(input int t, input int k, input int chan_w);
    int v;
    v = chan_w - 2 - t + k - 1;
    return ((v % chan_w) + chan_w) % chan_w;
  endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One MUX_SIZE:1 binary-select track mux. Select codes with no matching
// input drive 0 so unused encodings never float a track.
import sb_cfg_pkg::*;

module sb_track_mux #(
  parameter int MUX_SIZE = 2,
  parameter int SEL_W    = 1
) (
  input  logic [MUX_SIZE-1:0] mux_in,
  input  logic [SEL_W-1:0]    sel,
  output logic                mux_out
);

  // Decode the select; out-of-range codes leave the default 0.
  always_comb begin
    mux_out = 1'b0;
    for (int i = 0; i < MUX_SIZE; i++) begin
      if (sel == i[SEL_W-1:0]) mux_out = mux_in[i];
    end
  end

endmodule

// File: rtl/sb_param_cfgchain.sv
// Parametrised east/south switch block. Mux selects come from a serial
// config chain: a shadow shift register that is copied into the active
// register only on a validated commit, so live routing never glitches.
// Optional feature: define SB_CFG_PARITY_EN to append an even-parity bit
// (shadow[0]) that must check out before a commit is accepted.
import sb_cfg_pkg::*;

module sb_param_cfgchain #(
  parameter int CHAN_W   = 9,
  parameter int PIN_W    = 8,
  parameter int MUX_SIZE = 2
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic [CHAN_W-1:0] chanx_right_in,
  input  logic [CHAN_W-1:0] chany_bottom_in,
  input  logic [PIN_W-1:0]  right_pin_in,
  input  logic [PIN_W-1:0]  bottom_pin_in,
  input  logic              ccff_head,
  input  logic              cfg_shift,
  input  logic              cfg_commit,
  output logic [CHAN_W-1:0] chanx_right_out,
  output logic [CHAN_W-1:0] chany_bottom_out,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int SEL_W = sel_w(MUX_SIZE);
`ifdef SB_CFG_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CFG_BITS = 2 * CHAN_W * SEL_W + P;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  sb_cfg_state_e       state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                cfg_err_q, cfg_err_d;
  logic                parity_ok;
  logic                commit_eval;
  logic                commit_clash;
  logic [CHAN_W-1:0]   right_raw;
  logic [CHAN_W-1:0]   bottom_raw;

`ifdef SB_CFG_PARITY_EN
  assign parity_ok = ~(^shadow_q);
`else
  assign parity_ok = 1'b1;
`endif

  // A commit is honoured only once the chain is idle; one that overlaps a
  // shift is always a failure.
  assign commit_eval  = cfg_commit && !cfg_shift && (state_q == IDLE);
  assign commit_clash = cfg_commit && cfg_shift;

  // Next-state logic: FSM, shadow shift, bit counter and commit handling.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    bit_cnt_d   = bit_cnt_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;

    case (state_q)
      IDLE:    if (cfg_shift)  state_d = SHIFT;
      SHIFT:   if (!cfg_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cfg_shift) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
      if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (commit_clash) begin
      cfg_err_d = 1'b1;
      bit_cnt_d = '0;
    end else if (commit_eval) begin
      bit_cnt_d = '0;
      if ((bit_cnt_q == CNT_FULL) && parity_ok) begin
        active_d    = shadow_q;
        cfg_valid_d = 1'b1;
        cfg_err_d   = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  // Configuration state; any reset drops both the partial and live config.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      bit_cnt_q   <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar t = 0; t < CHAN_W; t++) begin : g_trk
    logic [MUX_SIZE-1:0] r_in;
    logic [MUX_SIZE-1:0] b_in;

    assign r_in[0] = right_pin_in[t % PIN_W];
    assign b_in[0] = bottom_pin_in[t % PIN_W];

    for (genvar k = 1; k < MUX_SIZE; k++) begin : g_in
      localparam int IDX = twist_idx(t, k, CHAN_W);
      assign r_in[k] = chany_bottom_in[IDX];
      assign b_in[k] = chanx_right_in[IDX];
    end

    sb_track_mux #(.MUX_SIZE(MUX_SIZE), .SEL_W(SEL_W)) u_right (
      .mux_in  (r_in),
      .sel     (active_q[P + t*SEL_W +: SEL_W]),
      .mux_out (right_raw[t])
    );

    sb_track_mux #(.MUX_SIZE(MUX_SIZE), .SEL_W(SEL_W)) u_bottom (
      .mux_in  (b_in),
      .sel     (active_q[P + (CHAN_W + t)*SEL_W +: SEL_W]),
      .mux_out (bottom_raw[t])
    );
  end

  assign chanx_right_out  = cfg_valid_q ? right_raw  : '0;
  assign chany_bottom_out = cfg_valid_q ? bottom_raw : '0;
  assign ccff_tail        = shadow_q[CFG_BITS-1];
  assign cfg_valid        = cfg_valid_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_sb_param_cfgchain.sv
// Scoreboard bench for sb_param_cfgchain: the driver applies config
// traffic and pushes expected outputs from a bit-history reference model;
// an independent monitor pops and compares at each falling clock edge.
module tb_sb_param_cfgchain;

  localparam int CHAN_W   = 9;
  localparam int PIN_W    = 8;
  localparam int MUX_SIZE = 2;
  localparam int SEL_W    = (MUX_SIZE <= 2) ? 1 : $clog2(MUX_SIZE);
`ifdef SB_CFG_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CFG_BITS = 2 * CHAN_W * SEL_W + P;

  logic              prog_clk = 1'b0;
  logic              prog_reset_n;
  logic [CHAN_W-1:0] chanx_right_in;
  logic [CHAN_W-1:0] chany_bottom_in;
  logic [PIN_W-1:0]  right_pin_in;
  logic [PIN_W-1:0]  bottom_pin_in;
  logic              ccff_head;
  logic              cfg_shift;
  logic              cfg_commit;
  logic [CHAN_W-1:0] chanx_right_out;
  logic [CHAN_W-1:0] chany_bottom_out;
  logic              ccff_tail;
  logic              cfg_valid;
  logic              cfg_err;

  sb_param_cfgchain #(.CHAN_W(CHAN_W), .PIN_W(PIN_W), .MUX_SIZE(MUX_SIZE)) dut (
    .prog_clk         (prog_clk),
    .prog_reset_n     (prog_reset_n),
    .chanx_right_in   (chanx_right_in),
    .chany_bottom_in  (chany_bottom_in),
    .right_pin_in     (right_pin_in),
    .bottom_pin_in    (bottom_pin_in),
    .ccff_head        (ccff_head),
    .cfg_shift        (cfg_shift),
    .cfg_commit       (cfg_commit),
    .chanx_right_out  (chanx_right_out),
    .chany_bottom_out (chany_bottom_out),
    .ccff_tail        (ccff_tail),
    .cfg_valid        (cfg_valid),
    .cfg_err          (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic              tail;
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: history of shifted bits, shift count since last
  // commit, last accepted config and the status flags.
  bit hist[$];
  int m_cnt;
  bit m_act[CFG_BITS];
  bit m_valid, m_err, m_prev_sh;

  task automatic m_reset();
    hist.delete();
    for (int i = 0; i < CFG_BITS; i++) hist.push_back(1'b0);
    for (int i = 0; i < CFG_BITS; i++) m_act[i] = 1'b0;
    m_cnt = 0; m_valid = 0; m_err = 0; m_prev_sh = 0;
  endtask

  // Shadow bit i is the bit shifted in i shifts ago.
  function automatic bit shadow_bit(input int i);
    return hist[CFG_BITS-1-i];
  endfunction

  task automatic m_edge(input bit sh, input bit hd, input bit cm);
    bit clash, eval, par;
    clash = cm && sh;
    eval  = cm && !sh && !m_prev_sh;
    if (eval) begin
      par = 0;
      foreach (hist[i]) par ^= hist[i];
      if (m_cnt == CFG_BITS && (P == 0 || par == 1'b0)) begin
        for (int i = 0; i < CFG_BITS; i++) m_act[i] = shadow_bit(i);
        m_valid = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
    end
    if (clash) m_err = 1;
    if (sh) begin
      hist.push_back(hd);
      void'(hist.pop_front());
    end
    if (clash || eval) m_cnt = 0;
    else if (sh) m_cnt++;
    m_prev_sh = sh;
  endtask

  function automatic int mux_sel(input int m);
    int s = 0;
    for (int b = 0; b < SEL_W; b++) if (m_act[P + m*SEL_W + b]) s |= (1 << b);
    return s;
  endfunction

  function automatic logic [CHAN_W-1:0] route(input logic [CHAN_W-1:0] chan,
                                              input logic [PIN_W-1:0] pins,
                                              input int base);
    logic [CHAN_W-1:0] o = '0;
    for (int t = 0; t < CHAN_W; t++) begin
      int s = mux_sel(base + t);
      if (s == 0) o[t] = pins[t % PIN_W];
      else if (s < MUX_SIZE) o[t] = chan[((CHAN_W - 3 - t + s) % CHAN_W + CHAN_W) % CHAN_W];
    end
    return m_valid ? o : '0;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, a, e, $time);
    end
  endtask

  // Monitor: every queued expectation is compared at the next falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge prog_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("cfg_valid", 32'(cfg_valid), 32'(e.valid));
        cmp("cfg_err", 32'(cfg_err), 32'(e.err));
        cmp("ccff_tail", 32'(ccff_tail), 32'(e.tail));
        cmp("chanx_right_out", 32'(chanx_right_out), 32'(e.r));
        cmp("chany_bottom_out", 32'(chany_bottom_out), 32'(e.b));
      end
    end
  end

  task automatic cycle(input bit sh, input bit hd, input bit cm);
    cfg_shift = sh; ccff_head = hd; cfg_commit = cm;
    @(posedge prog_clk);
    m_edge(sh, hd, cm);
    #1;
    cfg_commit = 1'b0;
  endtask

  task automatic check();
    exp_t e;
    chanx_right_in  = CHAN_W'($urandom);
    chany_bottom_in = CHAN_W'($urandom);
    right_pin_in    = PIN_W'($urandom);
    bottom_pin_in   = PIN_W'($urandom);
    e.valid = m_valid;
    e.err   = m_err;
    e.tail  = shadow_bit(CFG_BITS-1);
    e.r     = route(chany_bottom_in, right_pin_in, 0);
    e.b     = route(chanx_right_in, bottom_pin_in, CHAN_W);
    exp_q.push_back(e);
    @(negedge prog_clk);
    #1;
  endtask

  // mode: 0 all zeros, 1 all ones, 2 random bits; ends with one idle cycle.
  task automatic load(input int n, input int mode);
    for (int i = 0; i < n; i++)
      cycle(1'b1, (mode == 2) ? 1'($urandom) : 1'(mode), 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit_chk();
    cycle(1'b0, 1'b0, 1'b1);
    check();
  endtask

  task automatic do_reset();
    cfg_shift = 0; cfg_commit = 0; ccff_head = 0;
    prog_reset_n = 1'b0;
    m_reset();
    #2;
    check();
    prog_reset_n = 1'b1;
  endtask

  initial begin
    prog_reset_n = 1'b0;
    cfg_shift = 0; cfg_commit = 0; ccff_head = 0;
    chanx_right_in = '0; chany_bottom_in = '0; right_pin_in = '0; bottom_pin_in = '0;
    m_reset();
    #2;
    check();
    prog_reset_n = 1'b1;

    load(CFG_BITS, 1); commit_chk(); check(); check();
    load(CFG_BITS, 0); commit_chk(); check(); check();
    load(CFG_BITS - 1, 2); commit_chk(); check();
    load(CFG_BITS, 2); commit_chk();

    // Commit overlapping a shift, then a long stream to watch the tail.
    cycle(1'b1, 1'b1, 1'b1); check();
    for (int i = 0; i < 25; i++) begin
      cycle(1'b1, 1'($urandom), 1'b0);
      check();
    end
    cycle(1'b0, 1'b0, 1'b0);
    commit_chk();

    for (int it = 0; it < 30; it++) begin
      int n;
      n = ($urandom_range(0, 1) == 1) ? CFG_BITS : $urandom_range(CFG_BITS - 2, CFG_BITS + 2);
      load(n, 2);
      if ($urandom_range(0, 3) == 0) begin
        cycle(1'b1, 1'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
      end
      commit_chk();
    end

    load(CFG_BITS, 1); commit_chk();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'($urandom), 1'b0);
    do_reset();
    load(CFG_BITS, 2); commit_chk(); check();

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge prog_clk);
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
